// File: rtl/pipe_perf_monitor.sv
// pipe_perf_monitor: run-cycle and qualified pipeline-event counters with cycle limit and registered read port
module pipe_perf_monitor #(
  parameter int NUM_EVENTS = 4,
  parameter int CNT_WIDTH  = 32,
  parameter int SATURATE   = 0,
  parameter int SEL_W      = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  clear_i,
  input  logic [CNT_WIDTH-1:0]  limit_i,
  input  logic [NUM_EVENTS-1:0] event_i,
  input  logic [NUM_EVENTS-1:0] qual_i,
  input  logic [SEL_W-1:0]      rd_sel_i,
  output logic [CNT_WIDTH-1:0]  rd_data_o,
  output logic [1:0]            state_o,
  output logic                  done_o,
  output logic [NUM_EVENTS:0]   ovf_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nxt;
  // slot 0 is the cycle counter, slot k is event channel k-1
  logic [CNT_WIDTH-1:0] cnt     [NUM_EVENTS+1];
  logic [CNT_WIDTH-1:0] cnt_nxt [NUM_EVENTS+1];
  logic [NUM_EVENTS:0]  inc, full;
  logic [CNT_WIDTH-1:0] rd_nxt;
  logic                 run;
  assign run = state == RUN && !clear_i;
  assign inc = {event_i & qual_i, 1'b1} & {(NUM_EVENTS+1){run}};
  always_comb begin
    full = '0;
    for (int i = 0; i <= NUM_EVENTS; i++) begin
      full[i]    = &cnt[i];
      cnt_nxt[i] = !inc[i] ? cnt[i] : full[i] ? (SATURATE != 0 ? cnt[i] : '0) : cnt[i] + CNT_WIDTH'(1);
    end
  end
  always_comb begin
    rd_nxt = '0;
    for (int i = 0; i <= NUM_EVENTS; i++)
      if (rd_sel_i == SEL_W'(i)) rd_nxt = cnt[i];
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i <= NUM_EVENTS; i++) cnt[i] <= '0;
      ovf_o <= '0;
    end else if (clear_i) begin
      for (int i = 0; i <= NUM_EVENTS; i++) cnt[i] <= '0;
      ovf_o <= '0;
    end else begin
      for (int i = 0; i <= NUM_EVENTS; i++) cnt[i] <= cnt_nxt[i];
      ovf_o <= ovf_o | (inc & full);
    end
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rd_data_o <= '0;
    else       rd_data_o <= rd_nxt;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end
  // the limit is matched against the post-increment cycle count, so DONE lands on the Nth RUN edge
  always_comb begin
    state_nxt = clear_i ? IDLE
              : state == DONE ? DONE
              : state == RUN && limit_i != '0 && cnt_nxt[0] == limit_i ? DONE
              : start_i ? RUN : IDLE;
  end
  always_comb begin
    state_o = state;
    done_o  = state == DONE;
  end
endmodule

// File: tb/tb_pipe_perf_monitor.sv
// tb_pipe_perf_monitor: wrap and saturate instances checked against an increment-count reference model
module tb_pipe_perf_monitor;
  localparam int NE = 4;
  localparam int W  = 8;
  localparam int SW = 5;
  logic clk = 1'b0, rst, start, clr;
  logic [W-1:0] limit;
  logic [NE-1:0] ev, q;
  logic [SW-1:0] sel;
  logic [W-1:0] rd0, rd1;
  logic [1:0] st0, st1;
  logic dn0, dn1;
  logic [NE:0] ov0, ov1;
  int total = 0, bad = 0;
  int t [2][NE+1];
  int ms [2];
  int rexp [2];
  always #5 clk = ~clk;
  pipe_perf_monitor #(.NUM_EVENTS(NE), .CNT_WIDTH(W), .SATURATE(0), .SEL_W(SW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clr), .limit_i(limit), .event_i(ev), .qual_i(q),
    .rd_sel_i(sel), .rd_data_o(rd0), .state_o(st0), .done_o(dn0), .ovf_o(ov0));
  pipe_perf_monitor #(.NUM_EVENTS(NE), .CNT_WIDTH(W), .SATURATE(1), .SEL_W(SW)) dut_s (
    .clk_i(clk), .rst_i(rst), .start_i(start), .clear_i(clr), .limit_i(limit), .event_i(ev), .qual_i(q),
    .rd_sel_i(sel), .rd_data_o(rd1), .state_o(st1), .done_o(dn1), .ovf_o(ov1));
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // counts are kept as raw increment totals; wrap/saturate views are derived from them
  function automatic int val(int m, int i);
    return m == 0 ? t[m][i] % 256 : (t[m][i] > 255 ? 255 : t[m][i]);
  endfunction
  task automatic mreset();
    for (int m = 0; m < 2; m++) begin
      ms[m] = 0;
      rexp[m] = 0;
      for (int i = 0; i <= NE; i++) t[m][i] = 0;
    end
  endtask
  task automatic step();
    for (int m = 0; m < 2; m++) begin
      rexp[m] = int'(sel) <= NE ? val(m, int'(sel)) : 0;
      if (clr) begin
        ms[m] = 0;
        for (int i = 0; i <= NE; i++) t[m][i] = 0;
      end else if (ms[m] == 1) begin
        t[m][0]++;
        for (int k = 0; k < NE; k++) if (ev[k] && q[k]) t[m][k+1]++;
        ms[m] = (limit != 0 && val(m, 0) == int'(limit)) ? 2 : start ? 1 : 0;
      end else if (ms[m] == 0) ms[m] = start ? 1 : 0;
    end
  endtask
  task automatic vone(input int m, input logic [W-1:0] rd, input logic [1:0] st, input logic dn, input logic [NE:0] ov);
    logic [NE:0] eo;
    for (int i = 0; i <= NE; i++) eo[i] = t[m][i] >= 256;
    chk($sformatf("rd%0d", m), rd, rexp[m]);
    chk($sformatf("state%0d", m), st, ms[m]);
    chk($sformatf("done%0d", m), dn, ms[m] == 2);
    chk($sformatf("ovf%0d", m), ov, eo);
  endtask
  task automatic verify();
    vone(0, rd0, st0, dn0, ov0);
    vone(1, rd1, st1, dn1, ov1);
  endtask
  task automatic tick(input int s, input int e, input int qq, input int rs, input int c, input int lim);
    start = s != 0; ev = NE'(e); q = NE'(qq); sel = SW'(rs); clr = c != 0; limit = W'(lim);
    step();
    @(negedge clk);
    verify();
  endtask
  initial begin
    int lim;
    rst = 1'b1; start = 0; clr = 0; limit = '0; ev = '0; q = '0; sel = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    mreset();
    verify();
    for (int j = 0; j < 36; j++) tick(1, j % 3 == 0, j % 3 == 0, 0, 0, 30);
    tick(1, 1, 1, 0, 0, 30);
    chk("t1_cyc", rd0, 30);
    tick(1, 1, 1, 1, 0, 30);
    chk("t1_ch0", rd0, 10);
    chk("t1_ch0_sat", rd1, 10);
    chk("t1_state", st0, 2);
    chk("t1_done", dn0, 1);
    tick(0, 0, 0, 0, 1, 0);
    tick(1, 0, 0, 0, 0, 0);
    for (int j = 0; j < 8; j++) tick(1, 2, (8'b11010110 >> j) & 1 ? 2 : 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    for (int j = 0; j < 3; j++) tick(0, 15, 15, 2, 0, 0);
    chk("t2_ch1", rd0, 5);
    tick(0, 0, 0, 0, 1, 0);
    for (int j = 0; j < 5; j++) tick(1, 0, 0, 0, 0, 0);
    chk("t3_run1", st0, 1);
    for (int j = 0; j < 4; j++) tick(0, 0, 0, 0, 0, 0);
    chk("t3_idle", st0, 0);
    for (int j = 0; j < 5; j++) tick(1, 0, 0, 0, 0, 0);
    chk("t3_run2", st0, 1);
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    chk("t3_cyc", rd0, 10);
    chk("t3_done", dn0, 0);
    tick(0, 0, 0, 0, 1, 0);
    tick(1, 0, 0, 0, 0, 0);
    for (int j = 0; j < 260; j++) tick(1, 4, 4, 0, 0, 0);
    tick(0, 0, 0, 3, 0, 0);
    tick(0, 0, 0, 3, 0, 0);
    chk("t4_wrap", rd0, 4);
    chk("t4_sat", rd1, 255);
    chk("t4_ovf_wrap", ov0[3], 1);
    chk("t4_ovf_sat", ov1[3], 1);
    tick(1, 0, 0, 0, 0, 0);
    tick(1, 15, 15, 0, 0, 0);
    tick(1, 15, 15, 0, 1, 0);
    chk("t5_state", st0, 0);
    chk("t5_ovf", ov0, 0);
    tick(1, 15, 15, 0, 0, 0);
    chk("t5_rd", rd0, 0);
    chk("t5_run", st0, 1);
    for (int j = 0; j < 6; j++) tick(1, 15, 15, 0, 0, 0);
    #2 rst = 1'b1;
    #1;
    chk("t6_rd", rd0, 0);
    chk("t6_state", st0, 0);
    chk("t6_ovf", ov0, 0);
    chk("t6_rd_sat", rd1, 0);
    rst = 1'b0;
    mreset();
    for (int j = 0; j < 5; j++) tick(1, 15, 15, 1, 0, 0);
    tick(1, 15, 15, NE + 1, 0, 0);
    chk("t6_oob", rd0, 0);
    lim = 0;
    for (int j = 0; j < 500; j++) begin
      int c;
      c = $urandom_range(0, 39) == 0;
      if (c || $urandom_range(0, 59) == 0) begin
        case ($urandom_range(0, 4))
          0: lim = 0;
          1: lim = 20;
          2: lim = 60;
          3: lim = 200;
          default: lim = 255;
        endcase
      end
      tick($urandom_range(0, 9) != 0, $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 7), c, lim);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
